imem_dmem_arbiter: RTL and testbench

- Shares one single-port synchronous-read 32-bit RAM between the core's instruction-fetch port and its load/store data port.
- Lets the CPU run from a single unified memory (one BRAM) instead of split instruction/data memories.
- Arbitration is data-priority, with a starvation guard so fetch cannot be locked out indefinitely.
- Throughput is one access per cycle. Read latency is fixed at 1 cycle. Per-port stall counters are exported for debug.

---
 rtl/imem_dmem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : imem_dmem_arbiter
//  Purpose  : Shares one single-port, synchronous-read 32-bit RAM between the
//             instruction-fetch port (i_*) and the load/store port (d_*).
//             The data port has priority. A starvation guard lets fetch win
//             the next contended cycle after STARVE_MAX consecutive losses.
//             One access per cycle, fixed 1-cycle read latency, and
//             saturating per-port stall counters for debug.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W     byte-address width of both requester ports
//    STARVE_MAX consecutive contended fetch losses before fetch wins
//               (0 = pure data priority)
//    CNT_W      width of the saturating stall counters
//  Ports
//    clk, rst_n               clock, asynchronous active-low reset
//    i_req/i_addr             fetch request and byte address
//    i_gnt                    fetch granted this cycle (combinational)
//    i_rvalid/i_rdata         fetch response, one cycle after the grant
//    d_req/d_addr/d_we        data request, byte address, write select
//    d_wdata/d_wstrb          lane-aligned write data and byte enables
//    d_gnt                    data granted this cycle (combinational)
//    d_rvalid/d_rdata         data read response or write acknowledge
//    mem_en/mem_addr/mem_we   RAM access enable, word address, byte writes
//    mem_wdata/mem_rdata      RAM write data / read data (1-cycle latency)
//    i_stall_cnt/d_stall_cnt  cycles spent requesting without a grant
// ============================================================================
module imem_dmem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction-fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  // load/store port
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  // RAM side
  output logic              mem_en,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  // debug counters
  output logic [CNT_W-1:0]  i_stall_cnt,
  output logic [CNT_W-1:0]  d_stall_cnt
);

  // The loss counter needs to reach STARVE_MAX; keep at least one bit so the
  // guard-disabled build still elaborates cleanly.
  localparam int              LOSE_W   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [LOSE_W-1:0] LOSE_MAX = LOSE_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  // Owner of the response presented in the cycle after a grant.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_DRD  = 2'd2,
    OWN_DWR  = 2'd3
  } owner_t;

  owner_t              r_owner;
  owner_t              w_owner_nxt;
  logic [LOSE_W-1:0]   r_lose_cnt;
  logic [LOSE_W-1:0]   w_lose_nxt;
  logic [CNT_W-1:0]    r_i_stall;
  logic [CNT_W-1:0]    r_d_stall;

  logic                w_guard;
  logic                w_i_win;
  logic                w_d_win;
  logic                w_contend;

  // Byte-offset bits are not used for word-wide RAM accesses.
  logic                w_unused;
  assign w_unused = ^{i_addr[1:0], d_addr[1:0]};

  // --------------------------------------------------------------------------
  // Arbitration. Grants are gated by rst_n so nothing is granted (and the RAM
  // is not touched) while reset is held, even though the requests may be up.
  // --------------------------------------------------------------------------
  assign w_guard   = (STARVE_MAX > 0) && (r_lose_cnt == LOSE_MAX);
  assign w_contend = i_req & d_req;
  assign w_i_win   = rst_n & i_req & (~d_req | w_guard);
  assign w_d_win   = rst_n & d_req & (~i_req | ~w_guard);

  assign i_gnt = w_i_win;
  assign d_gnt = w_d_win;

  // --------------------------------------------------------------------------
  // RAM drive from the winner of this cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_we    = 4'b0000;
    mem_wdata = d_wdata;
    if (w_d_win) begin
      mem_en   = 1'b1;
      mem_addr = d_addr[ADDR_W-1:2];
      mem_we   = d_we ? d_wstrb : 4'b0000;
    end else if (w_i_win) begin
      mem_en   = 1'b1;
      mem_addr = i_addr[ADDR_W-1:2];
    end
  end

  // --------------------------------------------------------------------------
  // Response owner: next-state logic and registered state.
  // --------------------------------------------------------------------------
  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_i_win) begin
      w_owner_nxt = OWN_I;
    end else if (w_d_win) begin
      w_owner_nxt = d_we ? OWN_DWR : OWN_DRD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  // Response presentation. RAM data is steered to the owner only; the other
  // port and write acknowledges see zero data.
  always_comb begin
    i_rvalid = 1'b0;
    i_rdata  = 32'h0;
    d_rvalid = 1'b0;
    d_rdata  = 32'h0;
    case (r_owner)
      OWN_I: begin
        i_rvalid = 1'b1;
        i_rdata  = mem_rdata;
      end
      OWN_DRD: begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end
      OWN_DWR: begin
        d_rvalid = 1'b1;
      end
      default: begin
        i_rvalid = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Starvation guard. Counts consecutive contended cycles lost by fetch; any
  // cycle where fetch is granted or not requesting starts the count over.
  // With the guard disabled LOSE_MAX is 0, so the count never leaves 0.
  // --------------------------------------------------------------------------
  always_comb begin
    w_lose_nxt = '0;
    if (w_contend && w_d_win) begin
      w_lose_nxt = (r_lose_cnt == LOSE_MAX) ? r_lose_cnt : r_lose_cnt + LOSE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lose_cnt <= '0;
    end else begin
      r_lose_cnt <= w_lose_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating stall counters.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_stall <= '0;
      r_d_stall <= '0;
    end else begin
      if (i_req && !w_i_win && (r_i_stall != CNT_MAX)) begin
        r_i_stall <= r_i_stall + CNT_W'(1);
      end
      if (d_req && !w_d_win && (r_d_stall != CNT_MAX)) begin
        r_d_stall <= r_d_stall + CNT_W'(1);
      end
    end
  end

  assign i_stall_cnt = r_i_stall;
  assign d_stall_cnt = r_d_stall;

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_dmem_arbiter
//  Purpose  : Self-checking bench for imem_dmem_arbiter. A vector table of
//             requests with expected grants drives the main instance
//             (STARVE_MAX=3); expected responses go through a scoreboard
//             queue and are compared one cycle later. A second instance
//             (STARVE_MAX=0, CNT_W=4) covers pure data priority and counter
//             saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_dmem_arbiter;

  typedef struct {
    logic        ireq;
    logic [15:0] iaddr;
    logic        dreq;
    logic [15:0] daddr;
    logic        dwe;
    logic [31:0] dwdata;
    logic [3:0]  dwstrb;
    logic        eig;
    logic        edg;
  } vec_t;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        dv;
    logic [31:0] dd;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_en;
  logic [13:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata, mem_rdata;
  logic [15:0] i_stall_cnt, d_stall_cnt;

  // second instance
  logic        z_i_req, z_d_req;
  logic        z_i_gnt, z_i_rvalid, z_d_gnt, z_d_rvalid;
  logic [31:0] z_i_rdata, z_d_rdata;
  logic        z_mem_en;
  logic [13:0] z_mem_addr;
  logic [3:0]  z_mem_we;
  logic [31:0] z_mem_wdata;
  logic [31:0] z_mem_rdata;
  logic [3:0]  z_i_stall, z_d_stall;

  // RAM model plus bench-side preload path
  logic        pl_en;
  logic [13:0] pl_a;
  logic [31:0] pl_d;
  logic [31:0] ram     [0:16383];
  logic [31:0] ref_mem [0:16383];

  rsp_t  sbq[$];
  int    total;
  int    bad;
  int    exp_is;
  int    exp_ds;
  vec_t  tv[24];

  imem_dmem_arbiter #(.ADDR_W(16), .STARVE_MAX(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .i_stall_cnt(i_stall_cnt), .d_stall_cnt(d_stall_cnt)
  );

  imem_dmem_arbiter #(.ADDR_W(16), .STARVE_MAX(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_req(z_i_req), .i_addr(16'h0020), .i_gnt(z_i_gnt), .i_rvalid(z_i_rvalid), .i_rdata(z_i_rdata),
    .d_req(z_d_req), .d_addr(16'h0030), .d_we(1'b0), .d_wdata(32'h0), .d_wstrb(4'h0),
    .d_gnt(z_d_gnt), .d_rvalid(z_d_rvalid), .d_rdata(z_d_rdata),
    .mem_en(z_mem_en), .mem_addr(z_mem_addr), .mem_we(z_mem_we), .mem_wdata(z_mem_wdata),
    .mem_rdata(z_mem_rdata), .i_stall_cnt(z_i_stall), .d_stall_cnt(z_d_stall)
  );

  assign z_mem_rdata = 32'h5A5A_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_a] <= pl_d;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ireq, input logic [15:0] iaddr,
                              input logic dreq, input logic [15:0] daddr,
                              input logic dwe, input logic [31:0] dwdata,
                              input logic [3:0] dwstrb, input logic eig, input logic edg);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.daddr = daddr;
    v.dwe = dwe; v.dwdata = dwdata; v.dwstrb = dwstrb; v.eig = eig; v.edg = edg;
    return v;
  endfunction

  task automatic chk_reset();
    chk("rst_i_gnt",    32'(i_gnt), 32'd0);
    chk("rst_d_gnt",    32'(d_gnt), 32'd0);
    chk("rst_mem_en",   32'(mem_en), 32'd0);
    chk("rst_mem_we",   32'(mem_we), 32'd0);
    chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_i_stall",  32'(i_stall_cnt), 32'd0);
    chk("rst_d_stall",  32'(d_stall_cnt), 32'd0);
  endtask

  // One cycle: drive inputs just after the rising edge, check at the falling
  // edge, queue the response expected in the following cycle.
  task automatic step(input vec_t v);
    rsp_t r;
    rsp_t n;
    logic [13:0] wa;
    i_req = v.ireq; i_addr = v.iaddr;
    d_req = v.dreq; d_addr = v.daddr; d_we = v.dwe; d_wdata = v.dwdata; d_wstrb = v.dwstrb;
    @(negedge clk);
    chk("i_gnt",  32'(i_gnt), 32'(v.eig));
    chk("d_gnt",  32'(d_gnt), 32'(v.edg));
    chk("mem_en", 32'(mem_en), 32'(v.eig | v.edg));
    if (v.eig) chk("mem_addr_i", 32'(mem_addr), 32'(v.iaddr[15:2]));
    if (v.edg) chk("mem_addr_d", 32'(mem_addr), 32'(v.daddr[15:2]));
    chk("mem_we", 32'(mem_we), (v.edg && v.dwe) ? 32'(v.dwstrb) : 32'd0);
    if (v.edg && v.dwe) chk("mem_wdata", mem_wdata, v.dwdata);
    if (sbq.size() > 0) r = sbq.pop_front();
    else r = '{iv: 1'b0, id: 32'h0, dv: 1'b0, dd: 32'h0};
    chk("i_rvalid", 32'(i_rvalid), 32'(r.iv));
    chk("i_rdata",  i_rdata, r.id);
    chk("d_rvalid", 32'(d_rvalid), 32'(r.dv));
    chk("d_rdata",  d_rdata, r.dd);
    chk("i_stall_cnt", 32'(i_stall_cnt), 32'(exp_is));
    chk("d_stall_cnt", 32'(d_stall_cnt), 32'(exp_ds));
    n.iv = v.eig;
    n.id = v.eig ? ref_mem[v.iaddr[15:2]] : 32'h0;
    n.dv = v.edg;
    n.dd = (v.edg && !v.dwe) ? ref_mem[v.daddr[15:2]] : 32'h0;
    sbq.push_back(n);
    if (v.edg && v.dwe) begin
      wa = v.daddr[15:2];
      for (int b = 0; b < 4; b++) begin
        if (v.dwstrb[b]) ref_mem[wa][8*b +: 8] = v.dwdata[8*b +: 8];
      end
    end
    if (v.ireq && !v.eig) exp_is++;
    if (v.dreq && !v.edg) exp_ds++;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset for one cycle with both requests up, then release.
  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    sbq.delete();
    exp_is = 0; exp_ds = 0;
    @(negedge clk);
    chk_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0; exp_is = 0; exp_ds = 0;
    pl_en = 1'b0; pl_a = '0; pl_d = '0;
    z_i_req = 1'b0; z_d_req = 1'b0;
    i_addr = '0; d_addr = '0; d_we = 1'b0; d_wdata = '0; d_wstrb = '0;
    for (int k = 0; k < 8; k++) ref_mem[k] = 32'hA500_0000 + 32'(k);

    // ---- vector table ----
    //           ireq iaddr     dreq daddr     we  wdata          strb    ig   dg
    tv[0]  = mk(1, 16'h0008, 0, 16'h0000, 0, 32'h0,         4'h0, 1, 0); // fetch RAM[2]
    tv[1]  = mk(0, 16'h0000, 1, 16'h0010, 1, 32'hDEADBEEF,  4'hF, 0, 1); // full write
    tv[2]  = mk(1, 16'h0010, 0, 16'h0000, 0, 32'h0,         4'h0, 1, 0); // fetch new data
    tv[3]  = mk(0, 16'h0000, 1, 16'h0010, 1, 32'h11223344,  4'hF, 0, 1);
    tv[4]  = mk(0, 16'h0000, 1, 16'h0011, 1, 32'h0000AA00,  4'h2, 0, 1); // byte lane 1
    tv[5]  = mk(0, 16'h0000, 1, 16'h0010, 0, 32'h0,         4'h0, 0, 1); // read back
    tv[6]  = mk(0, 16'h0000, 0, 16'h0000, 0, 32'h0,         4'h0, 0, 0); // idle
    tv[7]  = mk(1, 16'h0000, 1, 16'h0008, 0, 32'h0,         4'h0, 0, 1); // contention
    tv[8]  = mk(1, 16'h0000, 1, 16'h000C, 1, 32'hCAFEF00D,  4'hF, 0, 1);
    tv[9]  = mk(1, 16'h0000, 1, 16'h000C, 0, 32'h0,         4'h0, 0, 1);
    tv[10] = mk(1, 16'h0000, 1, 16'h0014, 0, 32'h0,         4'h0, 1, 0); // guard fires
    tv[11] = mk(1, 16'h0004, 1, 16'h0014, 0, 32'h0,         4'h0, 0, 1);
    tv[12] = mk(1, 16'h0004, 1, 16'h0018, 0, 32'h0,         4'h0, 0, 1);
    tv[13] = mk(1, 16'h0004, 1, 16'h001C, 0, 32'h0,         4'h0, 0, 1);
    tv[14] = mk(1, 16'h0004, 1, 16'h0000, 0, 32'h0,         4'h0, 1, 0); // guard fires
    tv[15] = mk(0, 16'h0000, 0, 16'h0000, 0, 32'h0,         4'h0, 0, 0); // drain
    // after reset in flight: lose count must restart at 0
    tv[16] = mk(1, 16'h0008, 1, 16'h0000, 0, 32'h0,         4'h0, 0, 1);
    tv[17] = mk(1, 16'h0008, 1, 16'h0004, 0, 32'h0,         4'h0, 0, 1);
    tv[18] = mk(1, 16'h0008, 1, 16'h0008, 0, 32'h0,         4'h0, 0, 1);
    tv[19] = mk(1, 16'h0008, 1, 16'h000C, 0, 32'h0,         4'h0, 1, 0);
    tv[20] = mk(0, 16'h0000, 0, 16'h0000, 0, 32'h0,         4'h0, 0, 0);
    // pre-reset build-up for the in-flight test
    tv[21] = mk(1, 16'h0008, 1, 16'h0004, 0, 32'h0,         4'h0, 0, 1);
    tv[22] = mk(1, 16'h0008, 1, 16'h0008, 0, 32'h0,         4'h0, 0, 1);
    tv[23] = mk(0, 16'h0000, 0, 16'h0000, 0, 32'h0,         4'h0, 0, 0);

    // ---- reset held with both requests up; preload RAM meanwhile ----
    rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      pl_en = 1'b1; pl_a = 14'(k); pl_d = ref_mem[k];
      @(negedge clk);
      if (k == 0 || k == 7) chk_reset();
      @(posedge clk);
      #1;
    end
    pl_en = 1'b0;
    rst_n = 1'b1;

    // ---- table: fetch after reset, write/fetch, byte write, contention ----
    for (int k = 0; k <= 15; k++) step(tv[k]);
    chk("contend_i_stall", 32'(i_stall_cnt), 32'd6);
    chk("contend_d_stall", 32'(d_stall_cnt), 32'd2);
    chk("byte_write_word", ref_mem[4], 32'h1122AA44);

    // ---- reset while a data read response is in flight ----
    step(tv[21]);
    step(tv[22]);   // read granted; its response would appear next cycle
    do_reset();     // drop it: d_rvalid checked 0 during reset
    for (int k = 16; k <= 20; k++) step(tv[k]);

    // ---- guard disabled instance: data always wins, counter saturates ----
    z_i_req = 1'b1; z_d_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("z_d_gnt", 32'(z_d_gnt), 32'd1);
      chk("z_i_gnt", 32'(z_i_gnt), 32'd0);
      if (k > 0) chk("z_d_rvalid", 32'(z_d_rvalid), 32'd1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("z_i_stall_8", 32'(z_i_stall), 32'd8);
    chk("z_d_stall_0", 32'(z_d_stall), 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("z_i_stall_sat", 32'(z_i_stall), 32'd15);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("z_i_stall_hold", 32'(z_i_stall), 32'd15);
    z_i_req = 1'b0; z_d_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
